// File: rtl/bcd_pkg.sv
// Shared BCD digit type, 7-segment codes and decode helper
// for the event counter slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] bcd_to_seg(
    input bcd_digit_t d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd8_increment.sv
// Combinational +1 on one packed BCD byte (two digits),
// wrapping 99 -> 00.
module bcd8_increment
  import bcd_pkg::*;
(
  input  logic [7:0] d,
  output logic [7:0] q
);

  bcd_digit_t lo, hi;

  assign lo = d[3:0];
  assign hi = d[7:4];

  always_comb begin
    q = d;
    if (lo == 4'd9) begin
      q[3:0] = 4'd0;
      q[7:4] = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      q[3:0] = lo + 4'd1;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment scanner with
// leading-zero blanking and registered outputs.
module seg7_scan
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   digits,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_nxt;
  logic              tc;
  logic [DIGITS-1:0] blank;
  logic              zr;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] an_d;

  assign tc = (pre == PW'(SCAN_DIV - 1));

  always_comb begin
    idx_nxt = idx;
    if (tc)
      idx_nxt = (idx == IW'(DIGITS - 1)) ?
                '0 : idx + IW'(1);
  end

  // A digit blanks when it and every higher digit are zero
  always_comb begin
    zr    = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zr       = zr & (digits[4*i +: 4] == 4'd0);
      blank[i] = zr & (i != 0);
    end
  end

  always_comb begin
    seg_d = blank[idx_nxt] ? SEG_BLANK :
            bcd_to_seg(digits[4*idx_nxt +: 4]);
    an_d  = ~(DIGITS'(1) << idx_nxt);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre   <= '0;
      idx   <= '0;
      seg_n <= SEG_0;
      an_n  <= ~DIGITS'(1);
    end else begin
      pre   <= tc ? '0 : pre + PW'(1);
      idx   <= idx_nxt;
      seg_n <= seg_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Synchronised rising-edge event counter in packed BCD
// with sticky overflow and a scanned 7-segment display.
module bcd_event_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                evt_in,
  input  logic                clr,
  input  logic                hold,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                ovf,
  output logic [6:0]          seg_n,
  output logic [DIGITS-1:0]   an_n
);

  localparam int NB = DIGITS / 2;

  logic          s1, s2, s3;
  logic          evt_edge;
  logic          inc_en;
  logic [NB-1:0] byte_en;
  logic [8*NB-1:0] inc_q;
  logic          run9;
  logic          all9;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= evt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign evt_edge = s2 & ~s3;
  assign inc_en   = evt_edge & ~hold;

  // Carry into byte k is decoded from the stored lower bytes
  always_comb begin
    run9    = 1'b1;
    byte_en = '0;
    for (int k = 0; k < NB; k++) begin
      byte_en[k] = inc_en & run9;
      run9 = run9 & (count_bcd[8*k +: 8] == 8'h99);
    end
    all9 = run9;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_inc
    bcd8_increment u_inc (
      .d (count_bcd[8*gi +: 8]),
      .q (inc_q[8*gi +: 8])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_bcd <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      count_bcd <= '0;
      ovf       <= 1'b0;
    end else begin
      for (int k = 0; k < NB; k++)
        if (byte_en[k])
          count_bcd[8*k +: 8] <= inc_q[8*k +: 8];
      if (inc_en && all9)
        ovf <= 1'b1;
    end
  end

  seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .digits (count_bcd),
    .seg_n  (seg_n),
    .an_n   (an_n)
  );

endmodule

// File: tb/tb_bcd_event_counter.sv
// Directed bench for bcd_event_counter: counting, carry,
// wrap, clear, hold, scan/blanking and reset behaviour.
module tb_bcd_event_counter;

  logic        clk;
  logic        resetn;
  logic        evt_in;
  logic        clr;
  logic        hold;
  logic [15:0] count_bcd;
  logic        ovf;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  int n_chk;
  int n_fail;

  bcd_event_counter #(
    .DIGITS   (4),
    .SCAN_DIV (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .evt_in    (evt_in),
    .clr       (clr),
    .hold      (hold),
    .count_bcd (count_bcd),
    .ovf       (ovf),
    .seg_n     (seg_n),
    .an_n      (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // 2 cycles high, 2 low; count is settled on return
  task automatic pulse();
    @(negedge clk) evt_in = 1'b1;
    @(negedge clk);
    @(negedge clk) evt_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [3:0] an_exp  [4];
  logic [6:0] seg_exp [4];
  logic [3:0] prev_an;
  logic       synced;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_exp = '{7'h12, 7'h40, 7'h30, 7'h7F};
    resetn = 1'b0;
    evt_in = 1'b0;
    clr    = 1'b0;
    hold   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cnt", 32'(count_bcd), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_an",  32'(an_n), 32'hE);
    chk("rst_seg", 32'(seg_n), 32'h40);
    resetn = 1'b1;

    repeat (9) pulse();
    chk("cnt9", 32'(count_bcd), 32'h0009);
    pulse();
    chk("cnt10", 32'(count_bcd), 32'h0010);
    chk("ovf10", 32'(ovf), 32'h0);

    repeat (89) pulse();
    chk("cnt99", 32'(count_bcd), 32'h0099);
    pulse();
    chk("cnt100", 32'(count_bcd), 32'h0100);

    repeat (9899) pulse();
    chk("cnt9999", 32'(count_bcd), 32'h9999);
    chk("ovf9999", 32'(ovf), 32'h0);
    pulse();
    chk("wrap_cnt", 32'(count_bcd), 32'h0000);
    chk("wrap_ovf", 32'(ovf), 32'h1);

    repeat (42) pulse();
    chk("cnt42", 32'(count_bcd), 32'h0042);
    chk("ovf_sticky", 32'(ovf), 32'h1);

    // clr lands on the edge that carries the edge pulse
    @(negedge clk) evt_in = 1'b1;
    @(negedge clk);
    @(negedge clk) begin
      clr    = 1'b1;
      evt_in = 1'b0;
    end
    @(negedge clk) clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", 32'(count_bcd), 32'h0000);
    chk("clr_ovf", 32'(ovf), 32'h0);
    pulse();
    chk("clr_next", 32'(count_bcd), 32'h0001);

    @(negedge clk) hold = 1'b1;
    repeat (5) pulse();
    chk("hold5", 32'(count_bcd), 32'h0001);
    @(negedge clk) evt_in = 1'b1;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    repeat (2) @(negedge clk);
    evt_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_rel", 32'(count_bcd), 32'h0001);
    pulse();
    chk("hold_next", 32'(count_bcd), 32'h0002);

    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    repeat (305) pulse();
    chk("cnt305", 32'(count_bcd), 32'h0305);

    synced  = 1'b0;
    prev_an = an_n;
    for (int i = 0; i < 40 && !synced; i++) begin
      @(negedge clk);
      if (an_n == 4'hE && prev_an == 4'h7)
        synced = 1'b1;
      prev_an = an_n;
    end
    chk("scan_sync", 32'(synced), 32'h1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (s != 0 || c != 0)
          @(negedge clk);
        chk("scan_an",  32'(an_n),  32'(an_exp[s]));
        chk("scan_seg", 32'(seg_n), 32'(seg_exp[s]));
      end
    end

    @(negedge clk) evt_in = 1'b1;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mid_cnt", 32'(count_bcd), 32'h0);
    chk("mid_ovf", 32'(ovf), 32'h0);
    chk("mid_an",  32'(an_n), 32'hE);
    chk("mid_seg", 32'(seg_n), 32'h40);
    evt_in = 1'b0;
    @(negedge clk) resetn = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_nocnt", 32'(count_bcd), 32'h0);

    @(negedge clk) evt_in = 1'b1;
    @(negedge clk) evt_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch", 32'(count_bcd), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
